// File: rtl/wb_decoder.sv
// -----------------------------------------------------------------------------
// wb_decoder
//   Pipelined Wishbone address decoder: one master (J1 data bus) to N_SLAVES
//   slaves. Tracks the owner and count of in-flight requests so that acks and
//   read data are always taken from the slave that owns them, regardless of
//   what the master is currently presenting. Addresses that hit no slave are
//   answered by an internal default responder (ack one cycle after accept,
//   read data zero, writes dropped). A watchdog completes requests that a
//   slave never acknowledges (ack with all-ones data plus o_timeout pulse).
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_wbm_*             master request: adr, cyc, stb, we, dat (write data)
//   o_wbm_ack/stall/dat master response (dat = read data)
//   o_wbs_adr/we/dat    broadcast to every slave
//   o_wbs_cyc/stb[i]    per-slave cycle / strobe
//   i_wbs_ack/stall[i]  per-slave response flags
//   i_wbs_dat           per-slave read data, slave i at [i*DAT_W +: DAT_W]
//   o_timeout           one-cycle pulse when the watchdog fires
//
// SLV_BASE / SLV_MASK are listed slave 0 first, i.e. slave 0 occupies the
// most significant ADR_W bits of the packed parameter.
// -----------------------------------------------------------------------------
module wb_decoder #(
  parameter int                          N_SLAVES = 5,
  parameter int                          ADR_W    = 16,
  parameter int                          DAT_W    = 16,
  parameter logic [N_SLAVES*ADR_W-1:0]   SLV_BASE = {16'h0000, 16'h4000, 16'h5000, 16'h6000, 16'h7000},
  parameter logic [N_SLAVES*ADR_W-1:0]   SLV_MASK = {16'hC000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
  parameter int                          MAX_OUT  = 4,
  parameter int                          TIMEOUT  = 255
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  // master side
  input  logic [ADR_W-1:0]            i_wbm_adr,
  input  logic                        i_wbm_cyc,
  input  logic                        i_wbm_stb,
  input  logic                        i_wbm_we,
  input  logic [DAT_W-1:0]            i_wbm_dat,
  output logic                        o_wbm_ack,
  output logic                        o_wbm_stall,
  output logic [DAT_W-1:0]            o_wbm_dat,
  // slave side
  output logic [ADR_W-1:0]            o_wbs_adr,
  output logic                        o_wbs_we,
  output logic [DAT_W-1:0]            o_wbs_dat,
  output logic [N_SLAVES-1:0]         o_wbs_cyc,
  output logic [N_SLAVES-1:0]         o_wbs_stb,
  input  logic [N_SLAVES-1:0]         i_wbs_ack,
  input  logic [N_SLAVES-1:0]         i_wbs_stall,
  input  logic [N_SLAVES*DAT_W-1:0]   i_wbs_dat,
  // watchdog
  output logic                        o_timeout
);

  // Target / owner encoding: 0..N_SLAVES-1 real slaves, N_SLAVES default
  // responder, N_SLAVES+1 no owner.
  localparam int IW = $clog2(N_SLAVES + 2);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [IW-1:0] DEF      = IW'(N_SLAVES);
  localparam logic [IW-1:0] NONE     = IW'(N_SLAVES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  logic [IW-1:0]    r_cur;
  logic [CW-1:0]    r_cnt;
  logic [TW-1:0]    r_tmr;
  logic             r_def_ack;

  logic [IW-1:0]    w_tgt;
  logic             w_tgt_stall;
  logic             w_ok;
  logic             w_busy;
  logic             w_accept;
  logic             w_cur_ack;
  logic [DAT_W-1:0] w_cur_dat;
  logic             w_fwd_ack;
  logic             w_fire;
  logic             w_ret;
  logic [CW-1:0]    w_cnt_nxt;

  // Address decode. Scanning from the highest index down lets the lowest
  // matching index overwrite the others, so it wins on overlap.
  always_comb begin
    w_tgt = DEF;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((i_wbm_adr & SLV_MASK[(N_SLAVES-1-i)*ADR_W +: ADR_W]) ==
          SLV_BASE[(N_SLAVES-1-i)*ADR_W +: ADR_W]) begin
        w_tgt = IW'(i);
      end
    end
  end

  // Stall of the decoded target; the default responder never stalls.
  always_comb begin
    w_tgt_stall = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (w_tgt == IW'(i)) begin
        w_tgt_stall = i_wbs_stall[i];
      end
    end
  end

  // Return path is selected by the owner, never by the current decode.
  always_comb begin
    w_cur_ack = (r_cur == DEF) ? r_def_ack : 1'b0;
    w_cur_dat = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_cur == IW'(i)) begin
        w_cur_ack = i_wbs_ack[i];
        w_cur_dat = i_wbs_dat[i*DAT_W +: DAT_W];
      end
    end
  end

  assign w_busy   = (r_cnt != '0);
  // A new request may only join the current owner's stream, and never
  // beyond the outstanding limit.
  assign w_ok     = ((!w_busy) || (w_tgt == r_cur)) && (r_cnt < CNT_MAX);
  assign w_accept = i_wbm_cyc && i_wbm_stb && !o_wbm_stall;

  // Acks are only meaningful inside a live cycle with something in flight.
  assign w_fwd_ack = i_wbm_cyc && w_busy && w_cur_ack;
  // A real ack in the same cycle pre-empts the watchdog.
  assign w_fire    = i_wbm_cyc && w_busy && !w_cur_ack && (r_tmr == TMR_LAST);
  assign w_ret     = w_fwd_ack || w_fire;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_accept && !w_ret) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!w_accept && w_ret) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  // Master response
  assign o_wbm_stall = !w_ok || w_tgt_stall;
  assign o_wbm_ack   = w_ret;
  assign o_wbm_dat   = w_fire ? {DAT_W{1'b1}} : w_cur_dat;
  assign o_timeout   = w_fire;

  // Slave fan-out
  assign o_wbs_adr = i_wbm_adr;
  assign o_wbs_we  = i_wbm_we;
  assign o_wbs_dat = i_wbm_dat;

  // cyc stays up on the owner while its requests are in flight, even when
  // the master has already moved its address on to another slave.
  always_comb begin
    o_wbs_cyc = '0;
    o_wbs_stb = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      o_wbs_cyc[i] = i_wbm_cyc && ((w_busy && (r_cur == IW'(i))) || (w_tgt == IW'(i)));
      o_wbs_stb[i] = i_wbm_cyc && i_wbm_stb && w_ok && (w_tgt == IW'(i));
    end
  end

  // Tracking state. Dropping cyc aborts everything in flight, exactly like
  // reset, so late acks from the old owner find cnt==0 and are discarded.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wbm_cyc) begin
      r_cnt     <= '0;
      r_cur     <= NONE;
      r_tmr     <= '0;
      r_def_ack <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_def_ack <= w_accept && (w_tgt == DEF);

      if (w_accept) begin
        r_cur <= w_tgt;
      end else if (w_cnt_nxt == '0) begin
        r_cur <= NONE;
      end

      if (!w_busy || w_fwd_ack || w_accept || w_fire) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_decoder.sv
module tb_wb_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m_adr;
  logic        m_cyc, m_stb, m_we;
  logic [15:0] m_dat;
  logic [4:0]  s_ack, s_stall;
  logic [79:0] s_dat;

  // main instance: default limits except a short watchdog
  logic        d_ack, d_stall, d_to;
  logic [15:0] d_dat, d_sadr, d_sdat;
  logic        d_swe;
  logic [4:0]  d_cyc, d_stb;

  // second instance with a tight outstanding limit
  logic        l_ack, l_stall, l_to;
  logic [15:0] l_dat, l_sadr, l_sdat;
  logic        l_swe;
  logic [4:0]  l_cyc, l_stb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_decoder #(.MAX_OUT(4), .TIMEOUT(8)) u_dut (
    .i_clk(clk), .i_reset(reset),
    .i_wbm_adr(m_adr), .i_wbm_cyc(m_cyc), .i_wbm_stb(m_stb), .i_wbm_we(m_we), .i_wbm_dat(m_dat),
    .o_wbm_ack(d_ack), .o_wbm_stall(d_stall), .o_wbm_dat(d_dat),
    .o_wbs_adr(d_sadr), .o_wbs_we(d_swe), .o_wbs_dat(d_sdat),
    .o_wbs_cyc(d_cyc), .o_wbs_stb(d_stb),
    .i_wbs_ack(s_ack), .i_wbs_stall(s_stall), .i_wbs_dat(s_dat),
    .o_timeout(d_to)
  );

  wb_decoder #(.MAX_OUT(2), .TIMEOUT(8)) u_lim (
    .i_clk(clk), .i_reset(reset),
    .i_wbm_adr(m_adr), .i_wbm_cyc(m_cyc), .i_wbm_stb(m_stb), .i_wbm_we(m_we), .i_wbm_dat(m_dat),
    .o_wbm_ack(l_ack), .o_wbm_stall(l_stall), .o_wbm_dat(l_dat),
    .o_wbs_adr(l_sadr), .o_wbs_we(l_swe), .o_wbs_dat(l_sdat),
    .o_wbs_cyc(l_cyc), .o_wbs_stb(l_stb),
    .i_wbs_ack(s_ack), .i_wbs_stall(s_stall), .i_wbs_dat(s_dat),
    .o_timeout(l_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    s_ack = '0;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    m_adr = '0; m_dat = '0; s_stall = '0; s_dat = '0;
    do_reset();

    // ---------------- reset values ----------------
    #1;
    chk("rst_ack",     d_ack, 0);
    chk("rst_stall",   d_stall, 0);
    chk("rst_dat",     d_dat, 0);
    chk("rst_timeout", d_to, 0);
    chk("rst_cyc",     d_cyc, 0);
    chk("rst_stb",     d_stb, 0);
    chk("rst_cnt",     u_dut.r_cnt, 0);
    chk("rst_l_stall", l_stall, 0);
    nxt();

    // ---------------- pipelined reads, RAM ack 2 cycles later ----------------
    m_cyc = 1; m_stb = 1; m_we = 0; m_adr = 16'h0010;
    #1;
    chk("p_stall0", d_stall, 0);
    chk("p_stb0",   d_stb, 5'b00001);
    chk("p_ack0",   d_ack, 0);
    nxt();
    m_adr = 16'h0011;
    #1;
    chk("p_stall1", d_stall, 0);
    chk("p_ack1",   d_ack, 0);
    nxt();
    m_adr = 16'h0012; s_ack[0] = 1; s_dat[15:0] = 16'hA000;
    #1;
    chk("p_cnt_peak", u_dut.r_cnt, 2);
    chk("p_stall2",   d_stall, 0);
    chk("p_ack2",     d_ack, 1);
    chk("p_dat2",     d_dat, 16'hA000);
    nxt();
    m_adr = 16'h0013; s_dat[15:0] = 16'hA001;
    #1;
    chk("p_stall3", d_stall, 0);
    chk("p_dat3",   d_dat, 16'hA001);
    chk("p_cnt3",   u_dut.r_cnt, 2);
    nxt();
    m_stb = 0; s_dat[15:0] = 16'hA002;
    #1;
    chk("p_ack4", d_ack, 1);
    chk("p_dat4", d_dat, 16'hA002);
    nxt();
    s_dat[15:0] = 16'hA003;
    #1;
    chk("p_ack5", d_ack, 1);
    chk("p_dat5", d_dat, 16'hA003);
    nxt();
    s_ack = '0;
    #1;
    chk("p_ack_end", d_ack, 0);
    chk("p_cnt_end", u_dut.r_cnt, 0);
    nxt();

    // ---------------- slave switch RAM -> I/O ----------------
    m_stb = 1; m_adr = 16'h0020;
    #1;
    chk("s_stb_ram", d_stb, 5'b00001);
    nxt();
    m_adr = 16'h4000; s_dat[31:16] = 16'h1234;
    #1;
    chk("s_stall1", d_stall, 1);
    chk("s_stb1",   d_stb, 5'b00000);
    chk("s_cyc1",   d_cyc, 5'b00011);
    nxt();
    #1;
    chk("s_stall2", d_stall, 1);
    nxt();
    s_ack[0] = 1; s_dat[15:0] = 16'hBEEF;
    #1;
    chk("s_stall3",  d_stall, 1);
    chk("s_stb3",    d_stb, 5'b00000);
    chk("s_ram_ack", d_ack, 1);
    chk("s_ram_dat", d_dat, 16'hBEEF);
    nxt();
    s_ack = '0;
    #1;
    chk("s_issue_stall", d_stall, 0);
    chk("s_issue_stb",   d_stb, 5'b00010);
    nxt();
    m_stb = 0; s_ack[1] = 1;
    #1;
    chk("s_io_ack", d_ack, 1);
    chk("s_io_dat", d_dat, 16'h1234);
    nxt();
    s_ack = '0;

    // ---------------- unmapped: write then read ----------------
    m_stb = 1; m_we = 1; m_adr = 16'h8000; m_dat = 16'h5555; s_dat[15:0] = 16'hDEAD;
    #1;
    chk("u_stall_w", d_stall, 0);
    chk("u_stb_w",   d_stb, 0);
    chk("u_cyc_w",   d_cyc, 0);
    chk("u_bcast",   {d_swe, d_sdat}, {1'b1, 16'h5555});
    chk("u_ack_w0",  d_ack, 0);
    nxt();
    m_we = 0;
    #1;
    chk("u_ack_w",   d_ack, 1);
    chk("u_dat_w",   d_dat, 0);
    chk("u_stall_r", d_stall, 0);
    chk("u_stb_r",   d_stb, 0);
    nxt();
    m_stb = 0;
    #1;
    chk("u_ack_r", d_ack, 1);
    chk("u_dat_r", d_dat, 0);
    nxt();
    #1;
    chk("u_ack_end", d_ack, 0);
    nxt();

    // ---------------- watchdog ----------------
    m_stb = 1; m_adr = 16'h5000; s_dat[47:32] = 16'h0BAD;
    #1;
    chk("w_stb", d_stb, 5'b00100);
    nxt();
    m_stb = 0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      chk("w_quiet", {d_ack, d_to}, 2'b00);
      nxt();
    end
    #1;
    chk("w_fire_ack", d_ack, 1);
    chk("w_fire_to",  d_to, 1);
    chk("w_fire_dat", d_dat, 16'hFFFF);
    nxt();
    s_ack[2] = 1;
    #1;
    chk("w_cnt_after", u_dut.r_cnt, 0);
    chk("w_late_ack",  d_ack, 0);
    chk("w_to_once",   d_to, 0);
    nxt();
    s_ack = '0;

    // ---------------- MAX_OUT=2 limit (u_lim) ----------------
    do_reset();
    m_cyc = 1; m_stb = 1; m_adr = 16'h6000;
    #1;
    chk("m_stall0", l_stall, 0);
    chk("m_stb0",   l_stb, 5'b01000);
    nxt();
    #1;
    chk("m_stall1", l_stall, 0);
    nxt();
    #1;
    chk("m_stall2", l_stall, 1);
    chk("m_stb2",   l_stb, 0);
    nxt();
    #1;
    chk("m_stall3", l_stall, 1);
    nxt();
    s_ack[3] = 1; s_dat[63:48] = 16'h6001;
    #1;
    chk("m_stall_ack", l_stall, 1);
    chk("m_ack4",      l_ack, 1);
    chk("m_dat4",      l_dat, 16'h6001);
    nxt();
    s_ack = '0;
    #1;
    chk("m_issue_stall", l_stall, 0);
    chk("m_issue_stb",   l_stb, 5'b01000);
    nxt();
    m_stb = 0; s_ack[3] = 1;
    #1;
    chk("m_ack6", l_ack, 1);
    nxt();
    #1;
    chk("m_ack7", l_ack, 1);
    nxt();
    s_ack = '0;
    #1;
    chk("m_cnt_end", u_lim.r_cnt, 0);
    nxt();

    // ---------------- abort by dropping cyc ----------------
    do_reset();
    m_cyc = 1; m_stb = 1; m_adr = 16'h7000;
    nxt();
    nxt();
    m_cyc = 0; m_stb = 0;
    #1;
    chk("a_cyc_low", d_cyc, 0);
    chk("a_ack_low", d_ack, 0);
    nxt();
    s_ack[4] = 1;
    #1;
    chk("a_late_ack0", d_ack, 0);
    nxt();
    m_cyc = 1;
    #1;
    chk("a_late_ack1", d_ack, 0);
    chk("a_cnt",       u_dut.r_cnt, 0);
    nxt();
    s_ack = '0;

    // ---------------- reset mid-burst ----------------
    m_stb = 1; m_adr = 16'h7000;
    nxt();
    m_stb = 0; reset = 1;
    nxt();
    reset = 0; m_adr = 16'h8000; s_ack[4] = 1;
    #1;
    chk("r_ack",   d_ack, 0);
    chk("r_cnt",   u_dut.r_cnt, 0);
    chk("r_cyc",   d_cyc, 0);
    chk("r_stb",   d_stb, 0);
    chk("r_stall", d_stall, 0);
    chk("r_dat",   d_dat, 0);
    chk("r_to",    d_to, 0);
    nxt();
    s_ack = '0;
    m_stb = 1; m_adr = 16'h0030;
    #1;
    chk("r_next_stall", d_stall, 0);
    chk("r_next_stb",   d_stb, 5'b00001);
    nxt();
    m_stb = 0; s_ack[0] = 1; s_dat[15:0] = 16'h7777;
    #1;
    chk("r_next_ack", d_ack, 1);
    chk("r_next_dat", d_dat, 16'h7777);
    nxt();
    s_ack = '0; m_cyc = 0;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_decoder.md
# wb_decoder

Parametrised pipelined-Wishbone address decoder connecting one master (J1 data bus) to N_SLAVES slaves. It tracks outstanding transactions so acknowledges and read data are routed from the slave that owns the in-flight requests, not from whatever the current address decodes to. Unmapped addresses are answered by an internal default responder, and a watchdog completes requests that a slave never acknowledges. It sits between the J1 data-bus master and RAM/I/O in the system interconnect.

## Interface
- N_SLAVES, 5, number of slave ports (1..8)
- ADR_W, 16, address width
- DAT_W, 16, data width
- SLV_BASE, {16'h0000,16'h4000,16'h5000,16'h6000,16'h7000}, packed per-slave base addresses (ADR_W each)
- SLV_MASK, {16'hC000,16'hF000,16'hF000,16'hF000,16'hF000}, packed per-slave decode masks
- MAX_OUT, 4, maximum outstanding accepted-but-unacknowledged requests (1..15)
- TIMEOUT, 255, cycles without ack, while requests are outstanding, before the watchdog fires (≥2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wbm  if_wb.slave  ADR_W/DAT_W  master port (adr, cyc, stb, we, dat_o in; ack, stall, dat_i out)
- wbs[N_SLAVES]  if_wb.master  ADR_W/DAT_W  slave ports (adr, cyc, stb, we, dat_i out; ack, stall, dat_o in)
- timeout_o  out  1  one-cycle pulse when the watchdog fires

## Operation
- Decode: hit[i] = (wbm.adr & SLV_MASK[i]) == SLV_BASE[i]. The lowest index wins on overlap. No hit selects the default target DEF (index N_SLAVES).
- State: owner `cur` (0..N_SLAVES, or NONE), outstanding count `cnt` (0..MAX_OUT), watchdog timer `tmr`, default-responder ack flag.
- Routing permission: `ok` = (cnt==0 or target==cur) and cnt<MAX_OUT.
- Fan-out: adr, we and dat_i are broadcast to all slaves.
  - wbs[i].stb = wbm.cyc & wbm.stb & ok & target==i.
  - wbs[i].cyc = wbm.cyc & ((cnt>0 & cur==i) | target==i).
- wbm.stall:
  - 1 if !ok.
  - Otherwise the target slave's stall; 0 for DEF.
- Accept = wbm.cyc & wbm.stb & !wbm.stall. On accept, cur ← target.
- Return path:
  - Only the ack of cur is forwarded, and only while cnt>0. Acks from other slaves, or with cnt==0, are ignored.
  - wbm.dat_i = dat_o of cur; all-zero when cur is DEF or NONE.
- Default responder: acknowledges each accepted DEF request exactly one cycle later, with dat_i = 0. Writes are discarded.
- Count: cnt ← cnt + accept − ret, where ret = forwarded ack | watchdog fire. Accept and ret in the same cycle leave cnt unchanged.
- cur returns to NONE when cnt reaches 0 with no accept in that cycle.
- Watchdog:
  - tmr counts while cnt>0 and no ack is returned; it clears on any ack or accept, or when cnt==0.
  - When tmr reaches TIMEOUT−1: wbm.ack=1 with dat_i = all-ones, cnt decrements by 1, timeout_o pulses, tmr restarts.
  - A slave ack in the same cycle takes priority and the watchdog does not fire.
- Abort: wbm.cyc low forces cnt←0, cur←NONE, tmr←0 and clears the default-responder flag. Late slave acks are dropped.

## Timing
- Forward path is combinational: stb/adr reach the slave in the cycle presented.
- Return path adds zero latency for real slaves and exactly one cycle for DEF.
- Reset values: cnt=0, cur=NONE, tmr=0, timeout_o=0, wbm.ack=0, wbm.dat_i=0, all wbs[i].cyc/stb=0, wbm.stall=0 (cnt==0 and DEF is non-stalling).
- Reset mid-burst discards all outstanding state in the same edge; no ack is issued afterwards.
- Slave switch cost: the first request to a new slave stalls until the last ack from the previous owner has returned (cnt==0), then issues in the following cycle.
- cnt==MAX_OUT stalls the master even for the same slave; an ack in that cycle does not release the stall until the next cycle.

## Test plan
- Pipelined reads:
  - Stimulus: 4 back-to-back reads to 0x0010..0x0013; RAM acks 2 cycles after each request with data 0xA000+n.
  - Required: no stall; wbm.ack ×4 with 0xA000..0xA003 in order; cnt peaks at 2, ends at 0.
- Slave switch:
  - Stimulus: read 0x0020 (RAM, ack latency 3), then immediately read 0x4000.
  - Required: second request stalls 3 cycles; wbs[1].stb stays low until the RAM ack, then issues; the RAM ack data is not corrupted by the I/O decode.
- Unmapped:
  - Stimulus: write then read 0x8000.
  - Required: no slave stb; ack exactly 1 cycle after each accept; read data 0x0000.
- Watchdog (TIMEOUT=8):
  - Stimulus: read 0x5000 with slave never acking.
  - Required: wbm.ack and timeout_o at cycle 8 after accept with dat_i 0xFFFF; cnt=0; a subsequent ack from slave 2 is ignored.
- MAX_OUT limit (MAX_OUT=2):
  - Stimulus: 3 reads to 0x6000, slave acks late.
  - Required: third request stalls until the first ack, then issues the following cycle.
- Abort/reset:
  - Stimulus: drop cyc with 2 outstanding, then slave acks; separately assert reset mid-burst.
  - Required: no wbm.ack after the abort or reset; all outputs at reset values; the next transaction proceeds normally.
